// File: rtl/timer_dev_if.sv
// Bus port between the CPU bridge (master) and a countdown timer (slave).
// Carries the word-indexed load/store access and the interrupt line back.
interface timer_dev_if;
    logic [1:0]  Addr;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] DOut;
    logic        IRQ;

    modport master (
        output Addr,
        output WE,
        output DIn,
        input  DOut,
        input  IRQ
    );

    modport slave (
        input  Addr,
        input  WE,
        input  DIn,
        output DOut,
        output IRQ
    );
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer behind the CPU bridge.
// Word map: 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET, 2 COUNT, 3 reserved (reads 0).
// Optional feature: define TIMER_COUNT_WR_EN to make COUNT writable by software;
// without it COUNT is read-only and stores to it are dropped.
module timer_dev #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] PRESET_RST = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    timer_dev_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           r_state;
    logic             r_en;
    logic [1:0]       r_mode;
    logic             r_im;
    logic [CNT_W-1:0] r_preset;
    logic [CNT_W-1:0] r_count;
    logic             r_irqFlag;

    state_t           w_nextState;
    logic             w_nextEn;
    logic [1:0]       w_nextMode;
    logic             w_nextIm;
    logic [CNT_W-1:0] w_nextCount;
    logic             w_nextFlag;

    logic             w_ctrlWr;
    logic             w_presetWr;
    logic             w_enEff;
    logic [1:0]       w_modeEff;
    logic             w_autoReload;
    logic [31:0]      w_presetExt;
    logic [31:0]      w_countExt;
    logic [31:0]      w_rdData;

    assign w_ctrlWr   = bus.WE && (bus.Addr == 2'd0);
    assign w_presetWr = bus.WE && (bus.Addr == 2'd1);

    // A CTRL write is seen by the FSM at the same edge, so disabling or
    // switching mode never lets one more stale transition slip through.
    assign w_enEff      = w_ctrlWr ? bus.DIn[0]   : r_en;
    assign w_modeEff    = w_ctrlWr ? bus.DIn[2:1] : r_mode;
    assign w_autoReload = (w_modeEff == 2'd1);

    // Next-state and next-register computation; register writes are applied
    // last so software always wins over the FSM's own updates.
    always_comb begin
        w_nextState = r_state;
        w_nextEn    = r_en;
        w_nextMode  = r_mode;
        w_nextIm    = r_im;
        w_nextCount = r_count;
        w_nextFlag  = r_irqFlag;

        case (r_state)
            ST_IDLE: begin
                if (w_enEff) begin
                    w_nextState = ST_LOAD;
                end
            end
            ST_LOAD: begin
                w_nextCount = r_preset;
                w_nextState = ST_CNT;
            end
            ST_CNT: begin
                if (!w_enEff) begin
                    w_nextState = ST_IDLE;
                end else if (r_count == CNT_ZERO) begin
                    w_nextState = ST_INT;
                end else if (r_count == CNT_ONE) begin
                    w_nextCount = CNT_ZERO;
                    w_nextState = ST_INT;
                end else begin
                    w_nextCount = r_count - CNT_ONE;
                end
            end
            ST_INT: begin
                if (w_autoReload) begin
                    w_nextState = w_enEff ? ST_LOAD : ST_IDLE;
                end else begin
                    w_nextEn    = 1'b0;
                    w_nextFlag  = 1'b1;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        if (w_ctrlWr) begin
            w_nextEn   = bus.DIn[0];
            w_nextMode = bus.DIn[2:1];
            w_nextIm   = bus.DIn[3];
        end

        if (w_ctrlWr || w_presetWr) begin
            w_nextFlag = 1'b0;
        end

`ifdef TIMER_COUNT_WR_EN
        if (bus.WE && (bus.Addr == 2'd2)) begin
            w_nextCount = bus.DIn[CNT_W-1:0];
            w_nextState = r_state;
        end
`else
`endif
    end

    // FSM state plus the registers it owns (CTRL fields, COUNT, irq flag).
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_en      <= 1'b0;
            r_mode    <= 2'd0;
            r_im      <= 1'b0;
            r_count   <= CNT_ZERO;
            r_irqFlag <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_en      <= w_nextEn;
            r_mode    <= w_nextMode;
            r_im      <= w_nextIm;
            r_count   <= w_nextCount;
            r_irqFlag <= w_nextFlag;
        end
    end

    // PRESET only changes on a software write; a write during counting is
    // picked up at the next LOAD.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_preset <= PRESET_RST[CNT_W-1:0];
        end else if (w_presetWr) begin
            r_preset <= bus.DIn[CNT_W-1:0];
        end
    end

    // Zero-extend the CNT_W-wide registers to the 32-bit read bus.
    always_comb begin
        w_presetExt              = '0;
        w_countExt               = '0;
        w_presetExt[CNT_W-1:0]   = r_preset;
        w_countExt[CNT_W-1:0]    = r_count;
    end

    // Combinational read mux feeding the bridge; reads have no side effects.
    always_comb begin
        w_rdData = 32'h0;
        case (bus.Addr)
            2'd0:    w_rdData = {28'h0, r_im, r_mode, r_en};
            2'd1:    w_rdData = w_presetExt;
            2'd2:    w_rdData = w_countExt;
            default: w_rdData = 32'h0;
        endcase
    end

    assign bus.DOut = w_rdData;

    // Mode 0 holds a level via the flag; mode 1 pulses for the single INT cycle.
    assign bus.IRQ = r_im & (r_irqFlag | ((r_state == ST_INT) && (r_mode == 2'd1)));

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus a randomized run,
// all checked against a cycle-level behavioural model of the timer.
module tb_timer_dev;

    logic clk;
    logic reset;
    int   testsRun;
    int   testsFailed;

    timer_dev_if bus();

    timer_dev #(
        .CNT_W      (32),
        .PRESET_RST (32'h0)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: phases of one timer period as plain integers.
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_RUN  = 2;
    localparam int PH_FIRE = 3;

    logic        mEn;
    logic [1:0]  mMode;
    logic        mIm;
    logic [31:0] mPreset;
    logic [31:0] mCount;
    logic        mFlag;
    int          mPhase;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mEn     = 1'b0;
        mMode   = 2'd0;
        mIm     = 1'b0;
        mPreset = 32'h0;
        mCount  = 32'h0;
        mFlag   = 1'b0;
        mPhase  = PH_IDLE;
    endtask

    task automatic modelStep(input logic we, input logic [1:0] addr, input logic [31:0] din);
        bit          ctrlWr;
        bit          presetWr;
        bit          runOn;
        bit          periodic;
        logic        nEn;
        logic        nFlag;
        logic [31:0] nCount;
        int          nPhase;
        ctrlWr   = we && (addr == 2'd0);
        presetWr = we && (addr == 2'd1);
        runOn    = ctrlWr ? din[0] : mEn;
        periodic = ctrlWr ? (din[2:1] == 2'd1) : (mMode == 2'd1);
        nEn    = mEn;
        nFlag  = mFlag;
        nCount = mCount;
        nPhase = mPhase;
        if (mPhase == PH_IDLE && runOn) nPhase = PH_LOAD;
        if (mPhase == PH_LOAD) begin
            nCount = mPreset;
            nPhase = PH_RUN;
        end
        if (mPhase == PH_RUN) begin
            if (!runOn) nPhase = PH_IDLE;
            else if (mCount <= 1) begin
                nCount = 0;
                nPhase = PH_FIRE;
            end else nCount = mCount - 1;
        end
        if (mPhase == PH_FIRE) begin
            if (periodic) nPhase = runOn ? PH_LOAD : PH_IDLE;
            else begin
                nEn    = 1'b0;
                nFlag  = 1'b1;
                nPhase = PH_IDLE;
            end
        end
        if (ctrlWr) begin
            nEn   = din[0];
            mMode = din[2:1];
            mIm   = din[3];
        end
        if (ctrlWr || presetWr) nFlag = 1'b0;
        if (presetWr) mPreset = din;
`ifdef TIMER_COUNT_WR_EN
        if (we && addr == 2'd2) begin
            nCount = din;
            nPhase = mPhase;
        end
`endif
        mEn    = nEn;
        mFlag  = nFlag;
        mCount = nCount;
        mPhase = nPhase;
    endtask

    function automatic logic modelIrq();
        return mIm && (mFlag || (mPhase == PH_FIRE && mMode == 2'd1));
    endfunction

    // Non-intrusive register read: only Addr changes, no clock edge passes.
    task automatic readReg(input logic [1:0] addr, output logic [31:0] data);
        bus.WE   = 1'b0;
        bus.Addr = addr;
        #1;
        data = bus.DOut;
    endtask

    task automatic compareModel();
        logic [31:0] v;
        readReg(2'd0, v);
        checkOutput("ctrl", v, {28'h0, mIm, mMode, mEn});
        readReg(2'd1, v);
        checkOutput("preset", v, mPreset);
        readReg(2'd2, v);
        checkOutput("count", v, mCount);
        readReg(2'd3, v);
        checkOutput("rsvd", v, 32'h0);
        checkOutput("irq", {31'h0, bus.IRQ}, {31'h0, modelIrq()});
    endtask

    // One clock cycle: drive the access, step the model at the edge, compare.
    task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] din);
        bus.WE   = we;
        bus.Addr = addr;
        bus.DIn  = din;
        @(posedge clk);
        if (!reset) modelReset();
        else modelStep(we, addr, din);
        #1;
        bus.WE = 1'b0;
        compareModel();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 32'h0);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] held;
        int          pulses;
        int          lastPulse;
        int          seenIrq;
        bit          found;

        testsRun    = 0;
        testsFailed = 0;
        bus.WE   = 1'b0;
        bus.Addr = 2'd0;
        bus.DIn  = 32'h0;
        reset    = 1'b0;
        modelReset();

        // Reset held for two cycles while writes are attempted.
        applyStimulus(1'b1, 2'd0, 32'hF);
        applyStimulus(1'b1, 2'd1, 32'h5);
        readReg(2'd0, v);
        checkOutput("t1ctrl", v, 32'h0);
        readReg(2'd2, v);
        checkOutput("t1count", v, 32'h0);
        readReg(2'd1, v);
        checkOutput("t1preset", v, 32'h0);
        checkOutput("t1irq", {31'h0, bus.IRQ}, 32'h0);
        reset = 1'b1;

        // Mode 0 one-shot with IRQ enabled.
        applyStimulus(1'b1, 2'd1, 32'd5);
        applyStimulus(1'b1, 2'd0, 32'h9);
        for (int k = 5; k >= 0; k--) begin
            applyStimulus(1'b0, 2'd0, 32'h0);
            readReg(2'd2, v);
            checkOutput("t2count", v, 32'(k));
        end
        checkOutput("t2irqInt", {31'h0, bus.IRQ}, 32'h0);
        idle(1);
        checkOutput("t2irqUp", {31'h0, bus.IRQ}, 32'h1);
        readReg(2'd0, v);
        checkOutput("t2ctrl", v, 32'h8);
        idle(2);
        checkOutput("t2irqHold", {31'h0, bus.IRQ}, 32'h1);
        applyStimulus(1'b1, 2'd0, 32'h8);
        checkOutput("t2irqClr", {31'h0, bus.IRQ}, 32'h0);

        // Mode 1 auto-reload: pulses every PRESET+2 cycles.
        applyStimulus(1'b1, 2'd1, 32'd3);
        applyStimulus(1'b1, 2'd0, 32'hB);
        pulses    = 0;
        lastPulse = -1;
        for (int c = 1; c <= 20; c++) begin
            applyStimulus(1'b0, 2'd0, 32'h0);
            if (bus.IRQ) begin
                if (lastPulse >= 0) checkOutput("t3gap", 32'(c - lastPulse), 32'd5);
                lastPulse = c;
                pulses++;
            end
        end
        checkOutput("t3pulses", 32'(pulses), 32'd4);
        readReg(2'd0, v);
        checkOutput("t3ctrl", v, 32'hB);
        applyStimulus(1'b1, 2'd0, 32'h0);

        // Masked one-shot: flag sets, IRQ stays low; CTRL write clears the flag.
        applyStimulus(1'b1, 2'd1, 32'd2);
        applyStimulus(1'b1, 2'd0, 32'h1);
        seenIrq = 0;
        for (int c = 0; c < 8; c++) begin
            applyStimulus(1'b0, 2'd0, 32'h0);
            if (bus.IRQ) seenIrq++;
        end
        checkOutput("t4noIrq", 32'(seenIrq), 32'd0);
        readReg(2'd2, v);
        checkOutput("t4count", v, 32'h0);
        applyStimulus(1'b1, 2'd0, 32'h8);
        idle(1);
        checkOutput("t4unmask", {31'h0, bus.IRQ}, 32'h0);

        // Disable mid-count, then re-enable to reload.
        applyStimulus(1'b1, 2'd1, 32'd100);
        applyStimulus(1'b1, 2'd0, 32'h1);
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            applyStimulus(1'b0, 2'd0, 32'h0);
            readReg(2'd2, v);
            if (v == 32'd50) found = 1'b1;
        end
        checkOutput("t5reach50", {31'h0, found}, 32'h1);
        applyStimulus(1'b1, 2'd0, 32'h0);
        readReg(2'd2, held);
        checkOutput("t5hold", {31'h0, (held == 32'd49 || held == 32'd50)}, 32'h1);
        idle(3);
        readReg(2'd2, v);
        checkOutput("t5stay", v, held);
        checkOutput("t5irq", {31'h0, bus.IRQ}, 32'h0);
        applyStimulus(1'b1, 2'd0, 32'h1);
        idle(1);
        readReg(2'd2, v);
        checkOutput("t5reload", v, 32'd100);
        applyStimulus(1'b1, 2'd0, 32'h0);

        // COUNT write while counting.
        applyStimulus(1'b1, 2'd1, 32'd20);
        applyStimulus(1'b1, 2'd0, 32'h1);
        idle(3);
        readReg(2'd2, v);
        checkOutput("t6before", v, 32'd18);
        applyStimulus(1'b1, 2'd2, 32'd7);
        readReg(2'd2, v);
`ifdef TIMER_COUNT_WR_EN
        checkOutput("t6write", v, 32'd7);
`else
        checkOutput("t6write", v, 32'd17);
`endif
        idle(1);
        readReg(2'd2, v);
`ifdef TIMER_COUNT_WR_EN
        checkOutput("t6after", v, 32'd6);
`else
        checkOutput("t6after", v, 32'd16);
`endif
        applyStimulus(1'b1, 2'd0, 32'h0);

        // Randomized traffic, including occasional mid-run resets.
        for (int c = 0; c < 500; c++) begin
            logic        we;
            logic [1:0]  addr;
            logic [31:0] din;
            reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            we    = ($urandom_range(0, 3) == 0);
            addr  = 2'($urandom_range(0, 3));
            din   = $urandom;
            if (addr == 2'd0) din[0] = ($urandom_range(0, 3) != 0);
            if (addr == 2'd1) din = $urandom_range(0, 6);
            applyStimulus(we, addr, din);
        end
        reset = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
